uart_rx_fpga: RTL and testbench
===============================

# uart_rx_fpga

FPGA-side UART receiver that sits directly downstream of the chip's 64-bit packet transmitter. It oversamples the serial line on a fast system clock and frames one start bit (0), WIDTH data bits sent LSB-first, and one stop bit (1). It checks odd parity over the received word and presents the packet to readout logic through a valid/ack handshake.

## Interface
- WIDTH, 64, packet width in bits; bit WIDTH-1 is the odd-parity bit.
- OVERSAMPLE, 8, clk cycles per serial bit; must be even and >= 4.
- clk  input  1  system clock; all logic on posedge. Runs at OVERSAMPLE x the transmitter baud clock.
- reset_n  input  1  asynchronous, active-low reset.
- rx_in  input  1  serial line from the transmitter; idles high; asynchronous to clk.
- rx_data  output  WIDTH  last good packet; resets to 0.
- rx_valid  output  1  rx_data holds an unacknowledged packet; resets to 0.
- rx_ack  input  1  consumer accepts rx_data; ignored while rx_valid=0.
- rx_parity_err  output  1  ^rx_data == 0 for the packet in rx_data; same lifetime as rx_valid; resets to 0.
- rx_frame_err  output  1  one-cycle pulse when the stop bit samples 0; resets to 0.
- rx_overrun  output  1  one-cycle pulse when a good packet overwrites an unacked one; resets to 0.
- rx_busy  output  1  FSM is not in IDLE; resets to 0.

## Operation
- rx_in passes through a two-flop synchronizer that resets to 1. rx_s is the synchronized line.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: rx_s=0 -> START with cnt=0.
- START: at cnt=OVERSAMPLE/2-1, sample rx_s.
  - rx_s=1 -> IDLE (glitch; nothing reported).
  - rx_s=0 -> DATA with cnt=0, bitcnt=0.
- DATA: at cnt=OVERSAMPLE-1, sample rx_s into shift register bit position bitcnt (LSB-first), then cnt=0 and bitcnt+1.
  - After sampling bitcnt=WIDTH-1 -> STOP.
- STOP: at cnt=OVERSAMPLE-1, sample rx_s.
  - rx_s=1 -> load rx_data, set rx_valid=1, load rx_parity_err = ~(^word), go to IDLE.
  - rx_s=0 -> pulse rx_frame_err, discard the word, go to WAIT_HIGH. rx_data, rx_valid and rx_parity_err are unchanged.
- WAIT_HIGH: stay until rx_s=1, then go to IDLE. A held-low line (break) produces no further frames.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid on the next edge.
  - Good-frame load while rx_valid=1 and no rx_ack in the same cycle -> rx_data is overwritten, rx_valid stays 1, and rx_overrun pulses.
  - Load and rx_ack in the same cycle -> the new word is loaded, rx_valid stays 1, and there is no overrun.
- Counters: cnt is $clog2(OVERSAMPLE) bits; bitcnt is $clog2(WIDTH+1) bits. Neither wraps within a state.
- Reset mid-frame returns to IDLE immediately, clears all outputs, and sets the synchronizer to 1. The partial frame is lost.

## Timing
- Synchronizer latency: 2 clk cycles from an rx_in edge to rx_s.
- Let T0 be the edge on which IDLE sees rx_s=0. Sampling points relative to T0:
  - Start check at T0+OVERSAMPLE/2.
  - Data bit k at T0+OVERSAMPLE/2+(k+1)·OVERSAMPLE.
  - Stop bit at T0+OVERSAMPLE/2+(WIDTH+1)·OVERSAMPLE.
- rx_valid, rx_data, rx_parity_err and rx_overrun update on the stop-sample edge. rx_frame_err is high for exactly that following cycle.
- IDLE accepts a new start on the edge after the stop sample, so back-to-back frames with one stop bit are received without loss.
- Tolerated sender/receiver rate mismatch: ±(OVERSAMPLE/2-1)/OVERSAMPLE of a bit accumulated over WIDTH+2 bits.

## Structure
- Package uart_fpga_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, WAIT_HIGH};
  - the packet field constants: PKT_TYPE [1:0], CHIP_ID [9:2], CHANNEL_ID [15:10], TIMESTAMP [43:16], ADC_DATA [55:46], PARITY bit 63;
  - the configuration magic number 0x8950_4E47.
- Sub-module sync_2ff (parameter RESET_VAL) implements the synchronizer. Everything else lives in uart_rx_fpga.

## Test plan
- Clean frame, OVERSAMPLE=8, word 0xC000_0000_0000_0001 (odd parity) -> rx_valid at T0+524, rx_data=0xC000_0000_0000_0001, rx_parity_err=0. rx_ack clears rx_valid on the next cycle.
- Word 0x0000_0000_0000_0003 (even number of ones) -> rx_valid=1, rx_parity_err=1.
- 2-cycle low glitch on rx_in -> FSM returns to IDLE; no rx_valid or rx_frame_err. A following real frame is received correctly.
- Stop bit driven 0 and line held low 100 cycles -> one rx_frame_err pulse; FSM in WAIT_HIGH until the line is high; rx_valid unchanged.
- Two back-to-back frames with no ack -> second word in rx_data and one rx_overrun pulse. Repeat with rx_ack on the load cycle -> no overrun.
- reset_n asserted at data bit 30 -> all outputs 0 and rx_busy=0 immediately. The next full frame is received correctly.

Source files
------------

// File: rtl/uart_fpga_pkg.sv
// Shared types and packet layout for the FPGA-side UART receiver.
package uart_fpga_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} rx_state_t;

   // Field positions inside the 64-bit packet from the chip transmitter.
   localparam int unsigned PKT_TYPE_LSB   = 0;
   localparam int unsigned PKT_TYPE_MSB   = 1;
   localparam int unsigned CHIP_ID_LSB    = 2;
   localparam int unsigned CHIP_ID_MSB    = 9;
   localparam int unsigned CHANNEL_ID_LSB = 10;
   localparam int unsigned CHANNEL_ID_MSB = 15;
   localparam int unsigned TIMESTAMP_LSB  = 16;
   localparam int unsigned TIMESTAMP_MSB  = 43;
   localparam int unsigned ADC_DATA_LSB   = 46;
   localparam int unsigned ADC_DATA_MSB   = 55;
   localparam int unsigned PARITY_BIT     = 63;

   localparam logic [31:0] CFG_MAGIC = 32'h8950_4E47;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         q      <= RESET_VAL;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/uart_rx_fpga.sv
// Oversampling UART receiver: start, WIDTH data bits LSB-first, stop; odd parity check and
// valid/ack handshake towards readout logic.
module uart_rx_fpga
   import uart_fpga_pkg::*;
#(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned OVERSAMPLE = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             rx_in,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   input  logic             rx_ack,
   output logic             rx_parity_err,
   output logic             rx_frame_err,
   output logic             rx_overrun,
   output logic             rx_busy
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

   logic rx_s;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .d      (rx_in),
      .q      (rx_s)
   );

   rx_state_t        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [BW-1:0]    bitcnt_q, bitcnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
   logic             load;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      shift_d  = shift_q;
      ferr_d   = 1'b0;
      load     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!rx_s) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d    = '0;
               bitcnt_d = '0;
               state_d  = rx_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               // Right shift: after WIDTH samples the first bit received sits at bit 0.
               shift_d  = {rx_s, shift_q[WIDTH-1:1]};
               cnt_d    = '0;
               bitcnt_d = bitcnt_q + 1'b1;
               if (bitcnt_q == LAST_BIT) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_s) begin
                  load    = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake: an ack in the load cycle consumes the old word, so no overrun.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      perr_d  = perr_q;
      ovr_d   = 1'b0;
      if (load) begin
         data_d  = shift_q;
         valid_d = 1'b1;
         perr_d  = ~(^shift_q);
         ovr_d   = valid_q & ~rx_ack;
      end else if (valid_q && rx_ack) begin
         valid_d = 1'b0;
         perr_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         ovr_q    <= ovr_d;
      end
   end

   assign rx_data       = data_q;
   assign rx_valid      = valid_q;
   assign rx_parity_err = perr_q;
   assign rx_frame_err  = ferr_q;
   assign rx_overrun    = ovr_q;
   assign rx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fpga.sv
// Scoreboard bench for uart_rx_fpga: frames are serialised bit by bit and every packet load is
// checked against the word queued when that frame was sent.
module tb_uart_rx_fpga;
   import uart_fpga_pkg::*;

   localparam int OVS = 8;
   localparam int W   = 64;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          rx_in;
   logic [W-1:0]  rx_data;
   logic          rx_valid;
   logic          rx_ack;
   logic          rx_parity_err;
   logic          rx_frame_err;
   logic          rx_overrun;
   logic          rx_busy;

   int n_checks = 0;
   int n_errors = 0;
   int ovr_cnt  = 0;
   int ferr_cnt = 0;
   int base;

   logic [W:0]   exp_q[$];
   logic [W:0]   exp_e;
   logic         valid_prev = 1'b0;
   logic [W-1:0] data_prev  = '0;

   uart_rx_fpga #(
      .WIDTH     (W),
      .OVERSAMPLE(OVS)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .rx_in        (rx_in),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ack       (rx_ack),
      .rx_parity_err(rx_parity_err),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] make_pkt(input logic [1:0] ptype, input logic [7:0] chip,
                                            input logic [5:0] chan, input logic [27:0] ts,
                                            input logic [9:0] adc);
      logic [63:0] p;
      p = '0;
      p[PKT_TYPE_MSB:PKT_TYPE_LSB]     = ptype;
      p[CHIP_ID_MSB:CHIP_ID_LSB]       = chip;
      p[CHANNEL_ID_MSB:CHANNEL_ID_LSB] = chan;
      p[TIMESTAMP_MSB:TIMESTAMP_LSB]   = ts;
      p[ADC_DATA_MSB:ADC_DATA_LSB]     = adc;
      p[PARITY_BIT]                    = ~(^p[62:0]);
      return p;
   endfunction

   // Drive the first n frame bits ({stop, word, start}), OVS cycles each, from posedge+1.
   task automatic send_bits(input logic [W+1:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         rx_in = bits[i];
         repeat (OVS) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_good(input logic [W-1:0] w);
      exp_q.push_back({~(^w), w});
      send_bits({1'b1, w, 1'b0}, W + 2);
   endtask

   task automatic pulse_ack();
      rx_ack = 1'b1;
      @(posedge clk);
      #1;
      rx_ack = 1'b0;
   endtask

   // Monitor: a load is a rising rx_valid or a new word while rx_valid stays high.
   always @(negedge clk) begin
      if (rx_overrun)   ovr_cnt++;
      if (rx_frame_err) ferr_cnt++;
      if (reset_n && rx_valid && (!valid_prev || rx_data !== data_prev)) begin
         if (exp_q.size() == 0) begin
            check_eq("unexpected_load", 64'(rx_data), 64'h0);
         end else begin
            exp_e = exp_q.pop_front();
            check_eq("load_data", 64'(rx_data), 64'(exp_e[W-1:0]));
            check_eq("load_perr", 64'(rx_parity_err), 64'(exp_e[W]));
         end
      end
      valid_prev = rx_valid;
      data_prev  = rx_data;
   end

   initial begin
      logic [63:0] pkt;
      rx_in   = 1'b1;
      rx_ack  = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid", 64'(rx_valid), 64'h0);
      check_eq("rst_data", 64'(rx_data), 64'h0);
      check_eq("rst_flags", 64'({rx_parity_err, rx_frame_err, rx_overrun, rx_busy}), 64'h0);
      reset_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Clean frame with latency check: load edge is 527 edges after the start is driven.
      fork
         send_good(64'hC000_0000_0000_0001);
         begin
            repeat (526) @(posedge clk);
            #1;
            check_eq("lat_before", 64'(rx_valid), 64'h0);
            @(posedge clk);
            #1;
            check_eq("lat_at", 64'(rx_valid), 64'h1);
         end
      join
      check_eq("clean_perr", 64'(rx_parity_err), 64'h0);
      pulse_ack();
      check_eq("ack_clear", 64'(rx_valid), 64'h0);

      // Even number of ones.
      send_good(64'h0000_0000_0000_0003);
      check_eq("even_valid", 64'(rx_valid), 64'h1);
      check_eq("even_perr", 64'(rx_parity_err), 64'h1);
      pulse_ack();

      // Start-bit glitch, then a real field-built packet.
      rx_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rx_in = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check_eq("glitch_busy", 64'(rx_busy), 64'h0);
      check_eq("glitch_valid", 64'(rx_valid), 64'h0);
      check_eq("glitch_ferr", 64'(ferr_cnt), 64'h0);
      pkt = make_pkt(2'd2, 8'h5A, 6'h2C, CFG_MAGIC[27:0], 10'h3A7);
      send_good(pkt);
      check_eq("pkt_valid", 64'(rx_valid), 64'h1);

      // Frame error with held-low line; rx_valid and rx_data must survive.
      pulse_ack();
      send_good(64'h1111_2222_3333_4444);
      send_bits({1'b0, 64'hDEAD_BEEF_0BAD_F00D, 1'b0}, W + 2);
      repeat (100) @(posedge clk);
      #1;
      check_eq("ferr_count", 64'(ferr_cnt), 64'h1);
      check_eq("ferr_busy", 64'(rx_busy), 64'h1);
      check_eq("ferr_state", 64'(dut.state_q), 64'(WAIT_HIGH));
      check_eq("ferr_valid", 64'(rx_valid), 64'h1);
      check_eq("ferr_data", 64'(rx_data), 64'h1111_2222_3333_4444);
      rx_in = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check_eq("ferr_release", 64'(rx_busy), 64'h0);
      pulse_ack();

      // Back-to-back without ack: one overrun.
      base = ovr_cnt;
      send_good(64'h0123_4567_89AB_CDEF);
      send_good(64'hFEDC_BA98_7654_3210);
      check_eq("ovr_count", 64'(ovr_cnt - base), 64'h1);
      check_eq("ovr_data", 64'(rx_data), 64'hFEDC_BA98_7654_3210);
      check_eq("ovr_valid", 64'(rx_valid), 64'h1);

      // Ack on the load cycle: new word, valid stays, no overrun.
      base = ovr_cnt;
      fork
         send_good(64'hA5A5_5A5A_0F0F_F0F0);
         begin
            repeat (526) @(posedge clk);
            #1;
            pulse_ack();
         end
      join
      check_eq("ackload_ovr", 64'(ovr_cnt - base), 64'h0);
      check_eq("ackload_valid", 64'(rx_valid), 64'h1);
      check_eq("ackload_data", 64'(rx_data), 64'hA5A5_5A5A_0F0F_F0F0);

      // Reset around data bit 30, with a packet pending.
      send_bits({1'b1, 64'h7777_0000_FFFF_1234, 1'b0}, 32);
      repeat (4) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("midrst_valid", 64'(rx_valid), 64'h0);
      check_eq("midrst_data", 64'(rx_data), 64'h0);
      check_eq("midrst_flags", 64'({rx_parity_err, rx_frame_err, rx_overrun, rx_busy}), 64'h0);
      rx_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      send_good(64'h8000_0000_0000_0000);
      check_eq("postrst_valid", 64'(rx_valid), 64'h1);
      check_eq("postrst_perr", 64'(rx_parity_err), 64'h0);

      repeat (4) @(posedge clk);
      #1;
      check_eq("sb_empty", 64'(exp_q.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
